// File: rtl/seq_divider_pkg.sv
// Shared arithmetic-unit definitions used by the sequential divider and multiplier.
// State encoding and the divide-by-zero quotient constant live here.
package seq_divider_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIXUP = 2'd2
  } arith_state_t;

  // Quotient reported for a zero divisor: all ones in the low n bits (n <= 64).
  function automatic logic [63:0] div_zero_q(input int unsigned n);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift {P,Q} left, trial-subtract D, keep or restore.
module seq_divider_div_step #(
  parameter int N = 8
) (
  input  logic [N:0]   i_p,
  input  logic [N-1:0] i_q,
  input  logic [N-1:0] i_d,
  output logic [N:0]   o_p,
  output logic [N-1:0] o_q
);

  logic [N+1:0] w_p_sh;
  logic [N+1:0] w_trial;

  assign w_p_sh  = {i_p, i_q[N-1]};
  assign w_trial = w_p_sh - {2'b00, i_d};

  // A set top bit of the trial means it went negative: restore.
  always_comb begin
    if (w_trial[N+1]) begin
      o_p = w_p_sh[N:0];
      o_q = {i_q[N-2:0], 1'b0};
    end else begin
      o_p = w_trial[N:0];
      o_q = {i_q[N-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock, Start/Done handshake.
// Define DIV_SIGNED_EN for two's-complement operands with an extra sign-fixup cycle.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         Start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] Q,
  output logic [N-1:0] Rem,
  output logic         Busy,
  output logic         DivZero,
  output logic         Done
);

  localparam int CW = $clog2(N + 1);
  localparam logic [N-1:0] DZ_Q = N'(div_zero_q(N));

  arith_state_t r_state, w_state_nxt;
  logic [N:0]    r_p;
  logic [N-1:0]  r_q, r_d;
  logic [CW-1:0] r_cnt;
  logic          r_zpend;
  logic [N-1:0]  r_Q, r_Rem;
  logic          r_DivZero, r_Done;
  logic          w_accept;
  logic [N:0]    w_p_nxt;
  logic [N-1:0]  w_q_nxt;

`ifdef DIV_SIGNED_EN
  logic r_sa, r_sb;

  function automatic logic [N-1:0] mag(input logic [N-1:0] x);
    return x[N-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [N-1:0] apply_sign(input logic [N-1:0] x, input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction
`endif

  seq_divider_div_step #(.N(N)) u_step (
    .i_p (r_p),
    .i_q (r_q),
    .i_d (r_d),
    .o_p (w_p_nxt),
    .o_q (w_q_nxt)
  );

  // While a divide-by-zero result is pending, a new request waits one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (Start && !r_zpend) begin
          w_accept = 1'b1;
          if (B != '0) w_state_nxt = RUN;
        end
      end
      RUN: begin
        if (r_cnt == CW'(1)) begin
`ifdef DIV_SIGNED_EN
          w_state_nxt = FIXUP;
`else
          w_state_nxt = IDLE;
`endif
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_p       <= '0;
      r_q       <= '0;
      r_d       <= '0;
      r_cnt     <= '0;
      r_zpend   <= 1'b0;
      r_Q       <= '0;
      r_Rem     <= '0;
      r_DivZero <= 1'b0;
      r_Done    <= 1'b0;
`ifdef DIV_SIGNED_EN
      r_sa      <= 1'b0;
      r_sb      <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_Done  <= 1'b0;

      if (w_accept) begin
        r_p     <= '0;
        r_cnt   <= CW'(N);
        r_zpend <= (B == '0);
`ifdef DIV_SIGNED_EN
        r_q     <= (B == '0) ? A : mag(A);
        r_d     <= mag(B);
        r_sa    <= A[N-1];
        r_sb    <= B[N-1];
`else
        r_q     <= A;
        r_d     <= B;
`endif
      end

      // Zero divisor: r_q still holds the raw dividend.
      if (r_zpend) begin
        r_zpend   <= 1'b0;
        r_Q       <= DZ_Q;
        r_Rem     <= r_q;
        r_DivZero <= 1'b1;
        r_Done    <= 1'b1;
      end

      if (r_state == RUN) begin
        r_p   <= w_p_nxt;
        r_q   <= w_q_nxt;
        r_cnt <= r_cnt - CW'(1);
`ifndef DIV_SIGNED_EN
        if (r_cnt == CW'(1)) begin
          r_Q       <= w_q_nxt;
          r_Rem     <= w_p_nxt[N-1:0];
          r_DivZero <= 1'b0;
          r_Done    <= 1'b1;
        end
`endif
      end

`ifdef DIV_SIGNED_EN
      // Truncating division: quotient negative if signs differ, remainder follows A.
      if (r_state == FIXUP) begin
        r_Q       <= apply_sign(r_q, r_sa ^ r_sb);
        r_Rem     <= apply_sign(r_p[N-1:0], r_sa);
        r_DivZero <= 1'b0;
        r_Done    <= 1'b1;
      end
`endif
    end
  end

  assign Q       = r_Q;
  assign Rem     = r_Rem;
  assign DivZero = r_DivZero;
  assign Done    = r_Done;
  assign Busy    = (r_state != IDLE);

endmodule

// File: tb/tb_seq_divider.sv
// Directed and table-driven checks of seq_divider (N=8), plus unsigned random pairs.
module tb_seq_divider;

  localparam int N = 8;
`ifdef DIV_SIGNED_EN
  localparam int LAT = N + 1;
  localparam logic [N-1:0] Q_200_7 = 8'hF8;   // -56 / 7
  localparam logic [N-1:0] R_200_7 = 8'h00;
`else
  localparam int LAT = N;
  localparam logic [N-1:0] Q_200_7 = 8'd28;
  localparam logic [N-1:0] R_200_7 = 8'd4;
`endif

  logic         Clock = 1'b0;
  logic         Reset, Start;
  logic [N-1:0] A, B;
  logic [N-1:0] Q, Rem;
  logic         Busy, DivZero, Done;

  typedef struct {
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
  } vec_t;

  vec_t vecs[$];
  int n_tests = 0;
  int n_fail  = 0;

  seq_divider #(.N(N)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Q       (Q),
    .Rem     (Rem),
    .Busy    (Busy),
    .DivZero (DivZero),
    .Done    (Done)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at #1 after an edge; the next edge accepts the request.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    A = a;
    B = b;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
  endtask

  // Edges after the accepting edge until Done is seen; -1 if it never comes.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= LAT + 4; k++) begin
      @(posedge Clock);
      #1;
      if (Done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int lat;
    issue(v.a, v.b);
    check({tag, "_busy"}, Busy, (v.b != '0));
    wait_done(lat);
    check({tag, "_lat"}, lat, (v.b == '0) ? 1 : LAT);
    check({tag, "_q"}, Q, v.q);
    check({tag, "_rem"}, Rem, v.r);
    check({tag, "_dz"}, DivZero, v.dz);
    check({tag, "_idle"}, Busy, 0);
  endtask

  task automatic count_dones(input int edges, output int cnt);
    cnt = 0;
    for (int k = 0; k < edges; k++) begin
      @(posedge Clock);
      #1;
      if (Done) cnt++;
    end
  endtask

  initial begin
    int lat, cnt;
    vec_t v;

`ifdef DIV_SIGNED_EN
    vecs.push_back('{8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0});  // -7 / 2
    vecs.push_back('{8'h80, 8'hFF, 8'h80, 8'h00, 1'b0});  // overflow wrap
    vecs.push_back('{8'd13, 8'h00, 8'hFF, 8'd13, 1'b1});
    vecs.push_back('{8'h64, 8'hFD, 8'hDF, 8'h01, 1'b0});  // 100 / -3
    vecs.push_back('{8'h9C, 8'h03, 8'hDF, 8'hFF, 1'b0});  // -100 / 3
    vecs.push_back('{8'h80, 8'h00, 8'hFF, 8'h80, 1'b1});
`else
    vecs.push_back('{8'd200, 8'd7,   8'd28,  8'd4,   1'b0});
    vecs.push_back('{8'd13,  8'd0,   8'hFF,  8'd13,  1'b1});
    vecs.push_back('{8'd0,   8'd5,   8'd0,   8'd0,   1'b0});
    vecs.push_back('{8'd255, 8'd255, 8'd1,   8'd0,   1'b0});
    vecs.push_back('{8'd1,   8'd255, 8'd0,   8'd1,   1'b0});
    vecs.push_back('{8'd128, 8'd2,   8'd64,  8'd0,   1'b0});
    vecs.push_back('{8'd100, 8'd3,   8'd33,  8'd1,   1'b0});
    vecs.push_back('{8'h80,  8'hFF,  8'd0,   8'h80,  1'b0});
`endif

    Reset = 1'b1;
    Start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_q", Q, 0);
    check("rst_rem", Rem, 0);
    check("rst_dz", DivZero, 0);
    check("rst_done", Done, 0);
    check("rst_busy", Busy, 0);
    Reset = 1'b0;
    @(posedge Clock);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
      repeat (2) @(posedge Clock);
      #1;
    end

    // Back-to-back: second request raised in the Done cycle of the first.
    run_vec('{8'd255, 8'd1, 8'd255, 8'd0, 1'b0}, "b2b_first");
    check("b2b_done_hi", Done, 1);
    run_vec('{8'd5, 8'd9, 8'd0, 8'd5, 1'b0}, "b2b_second");
    repeat (3) @(posedge Clock);
    #1;
    check("hold_q", Q, 0);
    check("hold_rem", Rem, 5);
    check("hold_done", Done, 0);

    // Start pulsed at edge 3 of a running 200/7 must be ignored.
    issue(8'd200, 8'd7);
    repeat (2) @(posedge Clock);
    #1;
    A = 8'd100;
    B = 8'd3;
    Start = 1'b1;
    @(posedge Clock);
    #1;
    Start = 1'b0;
    lat = -1;
    for (int k = 4; k <= LAT + 4; k++) begin
      @(posedge Clock);
      #1;
      if (Done) begin
        lat = k;
        break;
      end
    end
    check("busy_start_lat", lat, LAT);
    check("busy_start_q", Q, Q_200_7);
    check("busy_start_rem", Rem, R_200_7);
    count_dones(LAT + 2, cnt);
    check("busy_start_no_2nd", cnt, 0);

    // Reset sampled at edge 4 of a fresh run aborts it with no Done.
    issue(8'd200, 8'd7);
    repeat (3) @(posedge Clock);
    #1;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    check("abort_q", Q, 0);
    check("abort_rem", Rem, 0);
    check("abort_dz", DivZero, 0);
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    count_dones(LAT + 2, cnt);
    check("abort_no_done", cnt, 0);

`ifndef DIV_SIGNED_EN
    for (int i = 0; i < 1000; i++) begin
      v.a = N'($urandom_range(0, 255));
      v.b = N'($urandom_range(1, 255));
      issue(v.a, v.b);
      wait_done(lat);
      check("rand_lat", lat, LAT);
      check("rand_q", Q, v.a / v.b);
      check("rand_rem", Rem, v.a % v.b);
      check("rand_inv", (16'(Q) * 16'(v.b) + 16'(Rem) == 16'(v.a)) && (Rem < v.b), 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring shift-subtract divider: N-bit unsigned dividend / N-bit divisor -> N-bit quotient + N-bit remainder, one quotient bit per clock.
Inverse companion of the team's shift-and-add multiplier; same Start/Done handshake so both can hang off the same arithmetic-unit controller.
Sits beside the multiplier in the Multiply/arith area; no memory, no bus interface.

Parameters:
N, 8, operand/result width in bits (N >= 2).

Ports:
Clock  input  1  rising-edge clock.
Reset  input  1  synchronous, active-high reset.
Start  input  1  request; sampled only in IDLE.
A  input  N  dividend; captured on the accepting edge.
B  input  N  divisor; captured on the accepting edge.
Q  output  N  quotient (registered).
Rem  output  N  remainder (registered).
Busy  output  1  high while an operation is in progress (state != IDLE).
DivZero  output  1  high with Done when captured B == 0; held with Q/Rem.
Done  output  1  single-cycle completion pulse (registered).

Behaviour:
- Reset (Reset=1 at posedge): Q=0, Rem=0, DivZero=0, Done=0, Busy=0, state=IDLE, internal registers cleared. Overrides everything, including mid-operation; no Done is produced for an aborted op.
- States: IDLE, RUN.
- IDLE: Done forced 0 each cycle (pulse). On Start=1: capture A into quotient shift reg, B into divisor reg, partial remainder (N+1 bits) = 0, Count = N.
  - B != 0 -> RUN.
  - B == 0 -> stay IDLE; next edge: Q = all ones, Rem = A, DivZero = 1, Done = 1. Latency 1 edge.
- RUN, each edge: shift {P, Qreg} left by 1; trial T = P_shifted - {0,B} ((N+1)-bit); if T >= 0 then P = T and new Qreg LSB = 1, else P kept and LSB = 0; Count decrements.
  - On the edge where Count == 1: Q = final quotient, Rem = P[N-1:0], DivZero = 0, Done = 1, state -> IDLE.
- Latency: Done high exactly N edges after the edge that accepted Start; Q/Rem/DivZero update on the same edge Done rises.
- Q, Rem, DivZero hold their values until the next completion or reset.
- Start while Busy: ignored, no queuing. Start high in the cycle Done is high: accepted (back-to-back issue, throughput N+1 cycles).
- A/B changes after acceptance have no effect.
- Invariant (unsigned, B != 0): A == Q*B + Rem, Rem < B.

Optional Feature:
DIV_SIGNED_EN
- Defined: A, B, Q, Rem are two's complement. Accept step records signs, divides magnitudes; one extra fixup cycle after the last iteration negates Q if signs differ, gives Rem the sign of A (truncating division). Latency N+1 edges. Overflow case -2^(N-1) / -1 -> Q = -2^(N-1) (wrap), Rem = 0, DivZero = 0. B == 0 -> Q = all ones, Rem = A, DivZero = 1, latency 1.
- Undefined: pure unsigned as above, latency N, no fixup state or sign logic synthesized.

Decomposition:
- Shared arith package: state encoding constants (IDLE, RUN, FIXUP) shared with the multiplier, DIV_ZERO quotient constant function (all ones for width N).
- One natural sub-module: div_step, combinational single iteration (shift, trial subtract, select, quotient bit); divider instantiates it once per cycle.

Test Plan:
- N=8, A=200, B=7, Start 1 cycle -> Busy for 8 cycles, Done 1 cycle at edge 8, Q=28, Rem=4, DivZero=0.
- A=255, B=1 -> Q=255, Rem=0; then A=5, B=9 issued in the Done cycle -> accepted, Q=0, Rem=5 eight edges later.
- A=13, B=0 -> Done at edge 1, Q=0xFF, Rem=13, DivZero=1, Busy never set.
- Start pulsed with A=100,B=3 at edge 3 of a 200/7 run -> ignored; result stays 28/4; Reset at edge 4 of a new run -> all outputs 0, no Done.
- Random 1000 unsigned pairs (B != 0) -> A == Q*B+Rem, Rem < B, Done exactly N edges after accept.
- DIV_SIGNED_EN: A=-7 (0xF9), B=2 -> Done at edge 9, Q=0xFD (-3), Rem=0xFF (-1); A=0x80, B=0xFF -> Q=0x80, Rem=0.
